tge_opb_cfg_sequencer: RTL and testbench

//  OPB master that programs the 10GbE core's software registers (dest_port, dest_ip, ...) from a table.

---
 rtl/tge_opb_cfg_sequencer.sv | 219 +++++++++++++++++++++
 tb/tb_tge_opb_cfg_sequencer.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tge_opb_cfg_sequencer.sv
// tge_opb_cfg_sequencer: OPB OR-bus master that writes a fixed register table into the
// 10GbE core's software registers (dest_port, dest_ip, ...) at boot, one write per entry.
// Optional build macro TGE_CFG_VERIFY_EN: read back each entry after its write and compare.
//
// Ports:
//   OPB_Clk, OPB_Rst         clock, asynchronous active-high reset
//   start                    1-cycle pulse; begins a sequence when not busy
//   busy / done / err        status; done and err are held until the next accepted start
//   err_idx                  table index of the entry that failed (valid when err)
//   tbl_idx                  registered table read index
//   tbl_abus / tbl_dbus      entry address/data, combinational from tbl_idx
//   M_*                      OPB master outputs (all zero whenever M_select is low)
//   Sl_*                     OR-ed OPB slave responses; Sl_DBus only used for readback
module tge_opb_cfg_sequencer #(
  parameter int N_ENTRIES = 8,
  parameter int IDX_W     = 3,
  parameter int TIMEOUT   = 16,
  parameter int MAX_RETRY = 4
) (
  input  logic             OPB_Clk,
  input  logic             OPB_Rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [IDX_W-1:0] err_idx,
  output logic [IDX_W-1:0] tbl_idx,
  input  logic [31:0]      tbl_abus,
  input  logic [31:0]      tbl_dbus,
  output logic [0:31]      M_ABus,
  output logic [0:31]      M_DBus,
  output logic [0:3]       M_BE,
  output logic             M_RNW,
  output logic             M_select,
  output logic             M_seqAddr,
  input  logic [0:31]      Sl_DBus,
  input  logic             Sl_xferAck,
  input  logic             Sl_errAck,
  input  logic             Sl_retry,
  input  logic             Sl_toutSup
);

  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam int RTY_W = $clog2(MAX_RETRY + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ENTRIES - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

  // S_RD is only ever entered when readback is built in.
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WR, S_GAP, S_NEXT, S_ERR, S_RD
  } state_t;

  state_t           state;
  logic [31:0]      addr_q;
  logic [31:0]      data_q;
  logic [TMR_W-1:0] timer;
  logic [RTY_W-1:0] retry_cnt;
  logic             rd_now;

`ifdef TGE_CFG_VERIFY_EN
  logic rd_phase;   // remembers whether a GAP returns to the read or the write
  assign rd_now = (state == S_RD);
`else
  logic unused_sl_dbus;
  assign rd_now         = 1'b0;
  assign unused_sl_dbus = ^Sl_DBus;
`endif

  assign M_seqAddr = 1'b0;

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      err_idx   <= '0;
      tbl_idx   <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      timer     <= '0;
      retry_cnt <= '0;
      M_select  <= 1'b0;
      M_RNW     <= 1'b0;
      M_ABus    <= '0;
      M_DBus    <= '0;
      M_BE      <= '0;
`ifdef TGE_CFG_VERIFY_EN
      rd_phase  <= 1'b0;
`endif
    end else begin
      // The bus is released every cycle unless a branch below keeps a
      // transfer running, so the OR-bus sees zeros whenever select is low.
      M_select <= 1'b0;
      M_RNW    <= 1'b0;
      M_ABus   <= '0;
      M_DBus   <= '0;
      M_BE     <= '0;

      case (state)
        S_IDLE, S_ERR: begin
          state <= S_IDLE;
          if (start) begin
            state   <= S_LOAD;
            tbl_idx <= '0;
            done    <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b1;
          end
        end

        S_LOAD: begin
          addr_q    <= tbl_abus;
          data_q    <= tbl_dbus;
          timer     <= '0;
          retry_cnt <= '0;
          state     <= S_WR;
          M_select  <= 1'b1;
          M_BE      <= 4'hF;
          M_ABus    <= tbl_abus;
          M_DBus    <= tbl_dbus;
`ifdef TGE_CFG_VERIFY_EN
          rd_phase  <= 1'b0;
`endif
        end

        S_GAP: begin
          timer    <= '0;
          M_select <= 1'b1;
          M_BE     <= 4'hF;
          M_ABus   <= addr_q;
`ifdef TGE_CFG_VERIFY_EN
          if (rd_phase) begin
            state <= S_RD;
            M_RNW <= 1'b1;
          end else begin
            state  <= S_WR;
            M_DBus <= data_q;
          end
`else
          state  <= S_WR;
          M_DBus <= data_q;
`endif
        end

        S_WR, S_RD: begin
          if (Sl_errAck) begin
            state   <= S_ERR;
            err     <= 1'b1;
            err_idx <= tbl_idx;
            busy    <= 1'b0;
          end else if (Sl_retry) begin
            // MAX_RETRY retries are tolerated; the next one aborts.
            if (retry_cnt == RTY_MAX) begin
              state   <= S_ERR;
              err     <= 1'b1;
              err_idx <= tbl_idx;
              busy    <= 1'b0;
            end else begin
              retry_cnt <= retry_cnt + 1'b1;
              state     <= S_GAP;
            end
          end else if (Sl_xferAck) begin
`ifdef TGE_CFG_VERIFY_EN
            if (!rd_now) begin
              // Write acknowledged: read the same address straight back.
              state     <= S_RD;
              rd_phase  <= 1'b1;
              timer     <= '0;
              retry_cnt <= '0;
              M_select  <= 1'b1;
              M_RNW     <= 1'b1;
              M_BE      <= 4'hF;
              M_ABus    <= addr_q;
            end else if (Sl_DBus == data_q) begin
              state <= S_NEXT;
            end else begin
              state   <= S_ERR;
              err     <= 1'b1;
              err_idx <= tbl_idx;
              busy    <= 1'b0;
            end
`else
            state <= S_NEXT;
`endif
          end else if (!Sl_toutSup && timer == TMR_LAST) begin
            state   <= S_ERR;
            err     <= 1'b1;
            err_idx <= tbl_idx;
            busy    <= 1'b0;
          end else begin
            // No response yet: keep the transfer on the bus. toutSup freezes the timer.
            if (!Sl_toutSup) timer <= timer + 1'b1;
            M_select <= 1'b1;
            M_RNW    <= rd_now;
            M_BE     <= 4'hF;
            M_ABus   <= addr_q;
            if (!rd_now) M_DBus <= data_q;
          end
        end

        S_NEXT: begin
          if (tbl_idx == LAST_IDX) begin
            state <= S_IDLE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            tbl_idx <= tbl_idx + 1'b1;
            state   <= S_LOAD;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tge_opb_cfg_sequencer.sv
module tb_tge_opb_cfg_sequencer;

  logic        OPB_Clk = 1'b0;
  logic        OPB_Rst = 1'b1;
  logic        start   = 1'b0;
  logic        busy, done, err;
  logic [0:0]  err_idx, tbl_idx;
  logic [31:0] tbl_abus, tbl_dbus;
  logic [0:31] M_ABus, M_DBus;
  logic [0:3]  M_BE;
  logic        M_RNW, M_select, M_seqAddr;
  logic [0:31] Sl_DBus;
  logic        Sl_xferAck, Sl_errAck, Sl_retry, Sl_toutSup;

  tge_opb_cfg_sequencer #(
    .N_ENTRIES(2), .IDX_W(1), .TIMEOUT(16), .MAX_RETRY(4)
  ) dut (
    .OPB_Clk(OPB_Clk), .OPB_Rst(OPB_Rst), .start(start),
    .busy(busy), .done(done), .err(err), .err_idx(err_idx), .tbl_idx(tbl_idx),
    .tbl_abus(tbl_abus), .tbl_dbus(tbl_dbus),
    .M_ABus(M_ABus), .M_DBus(M_DBus), .M_BE(M_BE), .M_RNW(M_RNW),
    .M_select(M_select), .M_seqAddr(M_seqAddr), .Sl_DBus(Sl_DBus),
    .Sl_xferAck(Sl_xferAck), .Sl_errAck(Sl_errAck), .Sl_retry(Sl_retry),
    .Sl_toutSup(Sl_toutSup)
  );

  always #5 OPB_Clk = ~OPB_Clk;

`ifdef TGE_CFG_VERIFY_EN
  localparam int  PHASES  = 2;
  localparam logic LAST_RNW = 1'b1;
`else
  localparam int  PHASES  = 1;
  localparam logic LAST_RNW = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  // Table contents.
  assign tbl_abus = tbl_idx[0] ? 32'h0100_0200 : 32'h0100_0100;
  assign tbl_dbus = tbl_idx[0] ? 32'h0A00_0001 : 32'h0000_EA60;

  // Slave model settings (written by the test tasks).
  int          resp_mode   = 0;   // 0 ack, 1 never ack, 2 errAck together with xferAck
  int          ack_lat     = 2;   // ack when this many select cycles have passed
  int          tout_hold   = 0;   // toutSup high for this many select cycles
  int          retry_limit = 0;   // retry while retries_seen < retry_limit
  logic [31:0] retry_addr  = 32'h0;
  logic [31:0] rd_flip     = 32'h0;

  // Slave model state.
  int          sel_cnt      = 0;
  int          retries_seen = 0;
  int          sel_cycles   = 0;
  int          rises        = 0;
  int          or_viol      = 0;
  int          be_viol      = 0;
  logic        prev_sel     = 1'b0;
  logic [31:0] last_wdata   = 32'h0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  assign Sl_xferAck = M_select && resp_mode != 1 && sel_cnt == ack_lat;
  assign Sl_errAck  = M_select && resp_mode == 2 && sel_cnt == ack_lat;
  assign Sl_retry   = M_select && sel_cnt == 0 && retries_seen < retry_limit && M_ABus == retry_addr;
  assign Sl_toutSup = M_select && sel_cnt < tout_hold;
  assign Sl_DBus    = (M_select && M_RNW) ? (last_wdata ^ rd_flip) : 32'h0;

  always @(posedge OPB_Clk) begin
    if (M_select && !Sl_xferAck && !Sl_errAck && !Sl_retry) sel_cnt <= sel_cnt + 1;
    else sel_cnt <= 0;
    if (Sl_retry) retries_seen <= retries_seen + 1;
  end

  always @(negedge OPB_Clk) begin
    prev_sel <= M_select;
    if (M_select) sel_cycles <= sel_cycles + 1;
    if (M_select && !prev_sel) rises <= rises + 1;
    if (!M_select && (M_ABus != 0 || M_DBus != 0 || M_BE != 0)) or_viol <= or_viol + 1;
    if (M_RNW && M_DBus != 0) or_viol <= or_viol + 1;
    if (M_select && M_BE != 4'hF) be_viol <= be_viol + 1;
    if (M_select && !M_RNW && Sl_xferAck && !Sl_errAck && !Sl_retry) begin
      wr_addr.push_back(M_ABus);
      wr_data.push_back(M_DBus);
      last_wdata <= M_DBus;
    end
  end

  task automatic pulse_start();
    @(negedge OPB_Clk); start = 1'b1;
    @(negedge OPB_Clk); start = 1'b0;
  endtask

  task automatic wait_idle(input int max, output bit to);
    int n;
    n = 0;
    @(negedge OPB_Clk);
    while (busy && n < max) begin
      @(negedge OPB_Clk);
      n++;
    end
    to = busy;
  endtask

  task automatic slave_default();
    resp_mode = 0; ack_lat = 2; tout_hold = 0; rd_flip = 32'h0;
    retry_limit = retries_seen;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge OPB_Clk);
    checks++;
    if ({busy, done, err, M_select, M_RNW, M_seqAddr} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b want 000000", {busy, done, err, M_select, M_RNW, M_seqAddr});
    end
    checks++;
    if (M_ABus !== 32'h0 || M_DBus !== 32'h0 || M_BE !== 4'h0) begin
      failures++;
      $display("FAIL reset_bus: got abus=%h dbus=%h be=%h want all 0", M_ABus, M_DBus, M_BE);
    end
    checks++;
    if (tbl_idx !== 1'b0 || err_idx !== 1'b0) begin
      failures++;
      $display("FAIL reset_idx: got tbl_idx=%b err_idx=%b want 0 0", tbl_idx, err_idx);
    end
    OPB_Rst = 1'b0;
  endtask

  task automatic test_basic();
    bit to;
    int n0, s0;
    slave_default();
    n0 = wr_addr.size(); s0 = sel_cycles;
    pulse_start();
    wait_idle(400, to);
    checks++;
    if (to) begin failures++; $display("FAIL basic_timeout: busy still %b after bound", busy); end
    checks++;
    if (wr_addr.size() != n0 + 2) begin
      failures++; $display("FAIL basic_count: got %0d writes want 2", wr_addr.size() - n0);
    end else begin
      checks++;
      if (wr_addr[n0] !== 32'h0100_0100 || wr_data[n0] !== 32'h0000_EA60) begin
        failures++; $display("FAIL basic_entry0: got %h:%h want 01000100:0000ea60", wr_addr[n0], wr_data[n0]);
      end
      checks++;
      if (wr_addr[n0+1] !== 32'h0100_0200 || wr_data[n0+1] !== 32'h0A00_0001) begin
        failures++; $display("FAIL basic_entry1: got %h:%h want 01000200:0a000001", wr_addr[n0+1], wr_data[n0+1]);
      end
    end
    checks++;
    if ({done, busy, err} !== 3'b100) begin
      failures++; $display("FAIL basic_status: got done/busy/err=%b want 100", {done, busy, err});
    end
    checks++;
    if (sel_cycles - s0 != 2 * 3 * PHASES) begin
      failures++; $display("FAIL basic_sel_cycles: got %0d want %0d", sel_cycles - s0, 2 * 3 * PHASES);
    end
  endtask

  task automatic test_timeout();
    bit to;
    int s0;
    slave_default();
    resp_mode = 1;
    s0 = sel_cycles;
    pulse_start();
    wait_idle(200, to);
    checks++;
    if (to) begin failures++; $display("FAIL tmo_bound: busy still %b after bound", busy); end
    checks++;
    if (sel_cycles - s0 != 16) begin
      failures++; $display("FAIL tmo_sel_cycles: got %0d want 16", sel_cycles - s0);
    end
    checks++;
    if ({err, done, err_idx} !== 3'b100) begin
      failures++; $display("FAIL tmo_status: got err/done/err_idx=%b want 100", {err, done, err_idx});
    end
    slave_default();
  endtask

  task automatic test_toutsup();
    bit to;
    int n0, s0;
    slave_default();
    ack_lat = 40; tout_hold = 40;
    n0 = wr_addr.size(); s0 = sel_cycles;
    pulse_start();
    wait_idle(800, to);
    checks++;
    if (to) begin failures++; $display("FAIL toutsup_bound: busy still %b", busy); end
    checks++;
    if ({done, err} !== 2'b10 || wr_addr.size() != n0 + 2) begin
      failures++; $display("FAIL toutsup_status: got done/err=%b writes=%0d want 10 2", {done, err}, wr_addr.size() - n0);
    end
    checks++;
    if (sel_cycles - s0 != 2 * 41 * PHASES) begin
      failures++; $display("FAIL toutsup_sel_cycles: got %0d want %0d", sel_cycles - s0, 2 * 41 * PHASES);
    end
    slave_default();
  endtask

  task automatic test_retry();
    bit to;
    int r0, q0;
    slave_default();
    retry_addr = 32'h0100_0200;
    retry_limit = retries_seen + 4;
    r0 = retries_seen; q0 = rises;
    pulse_start();
    wait_idle(400, to);
    checks++;
    if (to || {done, err} !== 2'b10) begin
      failures++; $display("FAIL retry4_status: got to=%0d done/err=%b want 0 10", to, {done, err});
    end
    checks++;
    if (retries_seen - r0 != 4) begin
      failures++; $display("FAIL retry4_count: got %0d want 4", retries_seen - r0);
    end
    checks++;
    if (rises - q0 != 6) begin
      failures++; $display("FAIL retry4_gaps: got %0d select rises want 6", rises - q0);
    end
    retry_limit = retries_seen + 5;
    r0 = retries_seen;
    pulse_start();
    wait_idle(400, to);
    checks++;
    if (to || {err, done, err_idx} !== 3'b101) begin
      failures++; $display("FAIL retry5_status: got to=%0d err/done/err_idx=%b want 0 101", to, {err, done, err_idx});
    end
    checks++;
    if (retries_seen - r0 != 5) begin
      failures++; $display("FAIL retry5_count: got %0d want 5", retries_seen - r0);
    end
    slave_default();
  endtask

  task automatic test_errack();
    bit to;
    int n0;
    slave_default();
    resp_mode = 2;
    n0 = wr_addr.size();
    pulse_start();
    wait_idle(200, to);
    checks++;
    if (to || {err, done, err_idx} !== 3'b100) begin
      failures++; $display("FAIL errack_status: got to=%0d err/done/err_idx=%b want 0 100", to, {err, done, err_idx});
    end
    checks++;
    if (wr_addr.size() != n0) begin
      failures++; $display("FAIL errack_writes: got %0d accepted writes want 0", wr_addr.size() - n0);
    end
    slave_default();
  endtask

  task automatic test_back_to_back();
    bit to;
    int n, n0;
    slave_default();
    ack_lat = 6;
    n0 = wr_addr.size();
    pulse_start();
    n = 0;
    while (tbl_idx !== 1'b1 && n < 200) begin @(negedge OPB_Clk); n++; end
    checks++;
    if (tbl_idx !== 1'b1) begin failures++; $display("FAIL b2b_reach: got tbl_idx=%b want 1", tbl_idx); end
    pulse_start();
    checks++;
    if (tbl_idx !== 1'b1 || busy !== 1'b1) begin
      failures++; $display("FAIL b2b_ignored: got tbl_idx=%b busy=%b want 1 1", tbl_idx, busy);
    end
    wait_idle(400, to);
    checks++;
    if (to || {done, err} !== 2'b10 || wr_addr.size() != n0 + 2) begin
      failures++; $display("FAIL b2b_status: got to=%0d done/err=%b writes=%0d want 0 10 2", to, {done, err}, wr_addr.size() - n0);
    end
  endtask

  task automatic test_start_on_final_ack();
    int n;
    slave_default();
    pulse_start();
    n = 0;
    while (!(tbl_idx === 1'b1 && M_select && Sl_xferAck && M_RNW === LAST_RNW) && n < 200) begin
      @(negedge OPB_Clk); n++;
    end
    checks++;
    if (n >= 200) begin failures++; $display("FAIL final_ack_reach: got n=%0d want final ack seen", n); end
    start = 1'b1;
    @(negedge OPB_Clk); start = 1'b0;
    repeat (4) @(negedge OPB_Clk);
    checks++;
    if ({busy, done, tbl_idx} !== 3'b011) begin
      failures++; $display("FAIL final_ack_start: got busy/done/tbl_idx=%b want 011", {busy, done, tbl_idx});
    end
  endtask

  task automatic test_reset_mid();
    int n;
    slave_default();
    resp_mode = 1;
    pulse_start();
    n = 0;
    while (!M_select && n < 20) begin @(negedge OPB_Clk); n++; end
    checks++;
    if (M_select !== 1'b1) begin failures++; $display("FAIL rst_mid_reach: got select=%b want 1", M_select); end
    OPB_Rst = 1'b1;
    #1;
    checks++;
    if (M_select !== 1'b0 || M_ABus !== 32'h0 || M_DBus !== 32'h0 || M_BE !== 4'h0) begin
      failures++; $display("FAIL rst_mid_bus: got sel=%b abus=%h dbus=%h be=%h want 0", M_select, M_ABus, M_DBus, M_BE);
    end
    checks++;
    if ({busy, done, err, tbl_idx, err_idx} !== 5'b0) begin
      failures++; $display("FAIL rst_mid_flags: got %b want 00000", {busy, done, err, tbl_idx, err_idx});
    end
    @(negedge OPB_Clk); OPB_Rst = 1'b0;
    slave_default();
    repeat (3) @(negedge OPB_Clk);
    checks++;
    if (busy !== 1'b0 || M_select !== 1'b0) begin
      failures++; $display("FAIL rst_mid_idle: got busy=%b sel=%b want 0 0", busy, M_select);
    end
  endtask

`ifdef TGE_CFG_VERIFY_EN
  task automatic test_verify();
    bit to;
    slave_default();
    rd_flip = 32'h1;   // readback 0x0000EA61 against 0x0000EA60
    pulse_start();
    wait_idle(200, to);
    checks++;
    if (to || {err, done, err_idx} !== 3'b100) begin
      failures++; $display("FAIL verify_mismatch: got to=%0d err/done/err_idx=%b want 0 100", to, {err, done, err_idx});
    end
    slave_default();
  endtask
`endif

  task automatic test_or_bus();
    checks++;
    if (or_viol != 0) begin failures++; $display("FAIL or_bus: got %0d violations want 0", or_viol); end
    checks++;
    if (be_viol != 0) begin failures++; $display("FAIL byte_enables: got %0d bad cycles want 0", be_viol); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_timeout();
    test_toutsup();
    test_retry();
    test_errack();
    test_back_to_back();
    test_start_on_final_ack();
    test_reset_mid();
`ifdef TGE_CFG_VERIFY_EN
    test_verify();
`endif
    test_or_bus();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
